// File: rtl/adc_readout_packer.sv
// rtl/adc_readout_packer.sv - frames 4-channel ADC FIFO words into a 32-bit AXI4-Stream with header, sequence and trailer.
// Optional checksum beat before the trailer: define ADC_READOUT_CHECKSUM_EN.
module adc_readout_packer #(
    parameter int          NUM_DATA               = 1280,
    parameter int          TRIGGER_COUNTER_LENGTH = 16,
    parameter int          SAMPLE_WIDTH           = 12,
    parameter int          TIMEOUT_CYCLES         = 4096,
    parameter logic [15:0] MAGIC                  = 16'hCB01
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [TRIGGER_COUNTER_LENGTH-1:0] trigger_count,
    input  logic [4*SAMPLE_WIDTH-1:0]         fifo_dout,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    output logic [31:0]                       m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic                              frame_active,
    output logic                              frame_error,
    output logic [31:0]                       frame_seq
);

    localparam int WR_W = $clog2(NUM_DATA + 1);
    localparam int ST_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef ADC_READOUT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA_LO, S_DATA_HI, S_CHECKSUM, S_TRAILER
    } state_t;
    localparam state_t S_END = S_CHECKSUM;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA_LO, S_DATA_HI, S_TRAILER
    } state_t;
    localparam state_t S_END = S_TRAILER;
`endif

    state_t                    state;
    state_t                    state_next;
    logic [15:0]               trig_q;
    logic [4*SAMPLE_WIDTH-1:0] sample_q;
    logic                      sample_vld;
    logic                      rd_pending;
    logic [WR_W-1:0]           words_requested;
    logic [15:0]               samples_sent;
    logic [ST_W-1:0]           starve_cnt;
    logic                      err;
`ifdef ADC_READOUT_CHECKSUM_EN
    logic [31:0]               csum;
`endif

    logic in_data;
    logic accept;
    logic hi_accept;
    logic data_accept;
    logic starving;
    logic timeout_hit;
    logic last_sample;

    function automatic logic [15:0] lane(input logic [4*SAMPLE_WIDTH-1:0] w, input int idx);
        return 16'(w[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
    endfunction

    assign in_data     = (state == S_DATA_LO) || (state == S_DATA_HI);
    assign accept      = m_axis_tvalid && m_axis_tready;
    assign hi_accept   = accept && (state == S_DATA_HI);
    assign data_accept = accept && in_data;
    assign last_sample = (samples_sent == 16'(NUM_DATA - 1));

    // One-word holding register: a read in flight counts as occupying it so a word is never overwritten.
    assign fifo_rd_en = ((state == S_HDR1) || in_data) && !fifo_empty &&
                        (words_requested < WR_W'(NUM_DATA)) && !rd_pending &&
                        (!sample_vld || hi_accept);

    // A cycle that issues a read is not starved; this also keeps an abort from stranding a read in flight.
    assign starving    = in_data && !sample_vld && !rd_pending && !fifo_rd_en;
    assign timeout_hit = starving && (starve_cnt == ST_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (!fifo_empty) state_next = S_HDR0;
            S_HDR0:    if (accept) state_next = S_HDR1;
            S_HDR1:    if (accept) state_next = S_DATA_LO;
            S_DATA_LO: begin
                if (timeout_hit)  state_next = S_END;
                else if (accept)  state_next = S_DATA_HI;
            end
            S_DATA_HI: begin
                if (accept)           state_next = last_sample ? S_END : S_DATA_LO;
                else if (timeout_hit) state_next = S_END;
            end
`ifdef ADC_READOUT_CHECKSUM_EN
            S_CHECKSUM: if (accept) state_next = S_TRAILER;
`endif
            S_TRAILER: if (accept) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 32'h0;
        m_axis_tlast  = 1'b0;
        frame_active  = (state != S_IDLE);
        case (state)
            S_HDR0: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {MAGIC, trig_q};
            end
            S_HDR1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = frame_seq;
            end
            S_DATA_LO: begin
                m_axis_tvalid = sample_vld;
                m_axis_tdata  = {lane(sample_q, 1), lane(sample_q, 0)};
            end
            S_DATA_HI: begin
                m_axis_tvalid = sample_vld;
                m_axis_tdata  = {lane(sample_q, 3), lane(sample_q, 2)};
            end
`ifdef ADC_READOUT_CHECKSUM_EN
            S_CHECKSUM: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = csum;
            end
`endif
            S_TRAILER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {err, 15'h0, samples_sent};
                m_axis_tlast  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_q          <= 16'h0;
            sample_q        <= '0;
            sample_vld      <= 1'b0;
            rd_pending      <= 1'b0;
            words_requested <= '0;
            samples_sent    <= 16'h0;
            starve_cnt      <= '0;
            err             <= 1'b0;
            frame_error     <= 1'b0;
            frame_seq       <= 32'h0;
        end else begin
            rd_pending  <= fifo_rd_en;
            frame_error <= timeout_hit;

            if (rd_pending) begin
                sample_q   <= fifo_dout;
                sample_vld <= 1'b1;
            end else if (hi_accept) begin
                sample_vld <= 1'b0;
            end

            if (state == S_IDLE && !fifo_empty) begin
                trig_q <= 16'(trigger_count);
            end

            if (state == S_HDR0) begin
                words_requested <= '0;
                samples_sent    <= 16'h0;
            end else begin
                if (fifo_rd_en) words_requested <= words_requested + 1'b1;
                if (hi_accept)  samples_sent    <= samples_sent + 16'h1;
            end

            if (state == S_HDR0 || data_accept) begin
                starve_cnt <= '0;
            end else if (starving) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (timeout_hit) begin
                err <= 1'b1;
            end else if (state == S_TRAILER && accept) begin
                err <= 1'b0;
            end

            if (state == S_TRAILER && accept) begin
                frame_seq <= frame_seq + 32'h1;
            end
        end
    end

`ifdef ADC_READOUT_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csum <= 32'h0;
        end else if (state == S_HDR0) begin
            csum <= 32'h0;
        end else if (data_accept) begin
            csum <= csum + m_axis_tdata;
        end
    end
`endif

endmodule

// File: tb/tb_adc_readout_packer.sv
// tb/tb_adc_readout_packer.sv - scoreboard bench for adc_readout_packer (honours ADC_READOUT_CHECKSUM_EN).
module tb_adc_readout_packer;

    localparam int ND = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] trigger_count = 16'h0;
    logic [47:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        frame_active;
    logic        frame_error;
    logic [31:0] frame_seq;

    adc_readout_packer #(
        .NUM_DATA               (ND),
        .TRIGGER_COUNTER_LENGTH (16),
        .SAMPLE_WIDTH           (12),
        .TIMEOUT_CYCLES         (TO),
        .MAGIC                  (16'hCB01)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .trigger_count (trigger_count),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_active  (frame_active),
        .frame_error   (frame_error),
        .frame_seq     (frame_seq)
    );

    always #5 clk = ~clk;

    // Capture FIFO model: first-word-fall-through disabled, data one cycle after rd_en.
    logic [47:0] mem [0:63];
    int pushed = 0;
    int popped = 0;
    assign fifo_empty = (pushed == popped);

    always @(posedge clk) begin
        if (fifo_rd_en && pushed != popped) begin
            fifo_dout <= mem[popped];
            popped    <= popped + 1;
        end
    end

    int tready_mode = 0;
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = (tready_mode == 0) ? 1'b1 : ((ph % 3) == 0);
            ph++;
        end
    end

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    logic [32:0] exp_q[$];
    chk_t        aux_q[$];
    int          tl_popped[$];
    int          checks = 0;
    int          fails = 0;
    int          beats = 0;
    int          err_pulses = 0;

    task automatic expect_eq(input string n, input logic [63:0] a, input logic [63:0] e);
        chk_t c;
        c.name = n;
        c.act  = a;
        c.exp  = e;
        aux_q.push_back(c);
    endtask

    // Monitor: sole owner of the comparison counters.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [32:0] e;
        chk_t        c;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            while (aux_q.size() > 0) begin
                c = aux_q.pop_front();
                checks++;
                if (c.act !== c.exp) begin
                    fails++;
                    $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
                end
            end
            if (!rstn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                        fails++;
                        $display("FAIL stall_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                    end
                end
                if (frame_error) err_pulses++;
                if (m_axis_tvalid && m_axis_tready) begin
                    beats++;
                    if (m_axis_tlast) tl_popped.push_back(popped);
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_beat: got l=%b d=%h expected none", m_axis_tlast, m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_axis_tlast, m_axis_tdata} !== e) begin
                            fails++;
                            $display("FAIL beat: got l=%b d=%h expected l=%b d=%h",
                                     m_axis_tlast, m_axis_tdata, e[32], e[31:0]);
                        end
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    task automatic push_word(input logic [47:0] w);
        mem[pushed] = w;
        pushed = pushed + 1;
    endtask

    task automatic enqueue_frame(input logic [15:0] trig, input logic [31:0] seq,
                                 input int start, input int nsamp, input logic err);
        logic [47:0] w;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] sum;
        sum = 32'h0;
        exp_q.push_back({1'b0, 16'hCB01, trig});
        exp_q.push_back({1'b0, seq});
        for (int i = 0; i < nsamp; i++) begin
            w  = mem[start + i];
            lo = {4'h0, w[23:12], 4'h0, w[11:0]};
            hi = {4'h0, w[47:36], 4'h0, w[35:24]};
            exp_q.push_back({1'b0, lo});
            exp_q.push_back({1'b0, hi});
            sum = sum + lo + hi;
        end
`ifdef ADC_READOUT_CHECKSUM_EN
        exp_q.push_back({1'b0, sum});
`endif
        exp_q.push_back({1'b1, err, 15'h0, 16'(nsamp)});
    endtask

    task automatic wait_seq(input logic [31:0] n);
        int k;
        k = 0;
        while (frame_seq != n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        expect_eq("frame_seq", 64'(frame_seq), 64'(n));
    endtask

    task automatic wait_beats(input int n);
        int k;
        k = 0;
        while (beats < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        expect_eq("beat_wait", 64'(beats >= n), 64'd1);
    endtask

    initial begin
        int start;
        int e0;
        int n0;
        int b0;

        repeat (3) @(negedge clk);
        expect_eq("rst_tvalid",     64'(m_axis_tvalid), 64'd0);
        expect_eq("rst_tlast",      64'(m_axis_tlast),  64'd0);
        expect_eq("rst_tdata",      64'(m_axis_tdata),  64'd0);
        expect_eq("rst_fifo_rd_en", 64'(fifo_rd_en),    64'd0);
        expect_eq("rst_active",     64'(frame_active),  64'd0);
        expect_eq("rst_error",      64'(frame_error),   64'd0);
        expect_eq("rst_seq",        64'(frame_seq),     64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Frame A: full frame, tready held high; trigger changes after latch are ignored.
        trigger_count = 16'h0007;
        start = popped;
        push_word(48'h123_456_789_ABC);
        push_word(48'hFFF_000_FFF_000);
        push_word(48'h001_002_003_004);
        push_word(48'hA5A_5A5_0F0_F0F);
        enqueue_frame(16'h0007, 32'd0, start, ND, 1'b0);
        repeat (3) @(negedge clk);
        trigger_count = 16'hFFFF;
        wait_seq(32'd1);

        // Frame B: tready one cycle on, two off.
        tready_mode = 1;
        trigger_count = 16'h0042;
        start = popped;
        push_word(48'h111_222_333_444);
        push_word(48'h555_666_777_888);
        push_word(48'h999_AAA_BBB_CCC);
        push_word(48'hDDD_EEE_FFF_000);
        enqueue_frame(16'h0042, 32'd1, start, ND, 1'b0);
        wait_seq(32'd2);
        tready_mode = 0;

        // Frame C: only two words arrive, frame is aborted by the starve timeout.
        trigger_count = 16'h0003;
        start = popped;
        push_word(48'h0AB_0CD_0EF_012);
        push_word(48'h345_678_9AB_CDE);
        enqueue_frame(16'h0003, 32'd2, start, 2, 1'b1);
        e0 = err_pulses;
        wait_seq(32'd3);
        expect_eq("frame_error_pulses", 64'(err_pulses - e0), 64'd1);
        expect_eq("timeout_reads", 64'(pushed - popped), 64'd0);

        // Frames D and E back to back from eight queued words.
        trigger_count = 16'h0100;
        start = popped;
        for (int i = 0; i < 8; i++) push_word(48'(i * 48'h010_020_030_040 + 48'h1));
        enqueue_frame(16'h0100, 32'd3, start, ND, 1'b0);
        enqueue_frame(16'h0100, 32'd4, start + ND, ND, 1'b0);
        n0 = tl_popped.size();
        wait_seq(32'd5);
        expect_eq("reads_frame_d", 64'(tl_popped[n0] - start), 64'd4);
        expect_eq("reads_frame_e", 64'(tl_popped[n0 + 1] - start), 64'd8);

        // Frame with all channels 12'h001: each data beat is 00010001.
        trigger_count = 16'h0005;
        start = popped;
        for (int i = 0; i < 4; i++) push_word(48'h001_001_001_001);
        exp_q.push_back({1'b0, 32'hCB010005});
        exp_q.push_back({1'b0, 32'h00000005});
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 32'h00010001});
`ifdef ADC_READOUT_CHECKSUM_EN
        exp_q.push_back({1'b0, 32'h00080008});
`endif
        exp_q.push_back({1'b1, 32'h00000004});
        wait_seq(32'd6);

        // Frame F: reset while in DATA_HI, then restart from sequence 0.
        trigger_count = 16'h00AA;
        start = popped;
        for (int i = 0; i < 4; i++) push_word(48'hC00_C01_C02_C03 + 48'(i));
        enqueue_frame(16'h00AA, 32'd6, start, ND, 1'b0);
        b0 = beats;
        wait_beats(b0 + 3);
        #2;
        rstn = 1'b0;
        #1;
        expect_eq("async_tvalid",     64'(m_axis_tvalid), 64'd0);
        expect_eq("async_active",     64'(frame_active),  64'd0);
        expect_eq("async_fifo_rd_en", 64'(fifo_rd_en),    64'd0);
        expect_eq("async_seq",        64'(frame_seq),     64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_word(48'h7FF_800_001_FFE);
        expect_eq("fifo_left", 64'(pushed - popped), 64'd4);
        trigger_count = 16'h00BB;
        enqueue_frame(16'h00BB, 32'd0, popped, ND, 1'b0);
        rstn = 1'b1;
        wait_seq(32'd1);

        begin
            int k;
            k = 0;
            while (exp_q.size() != 0 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        expect_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adc_readout_packer.md
Name: adc_readout_packer

Overview:
- Reads 4-channel AD9228 samples from the capture FIFO after a chip readout and frames them into a 32-bit AXI4-Stream for the DMA.
- Sits between the capture FIFO write side (driven by the readout sequencer's FIFO write enable) and the AXIS DMA.
- Adds header, sequence and trailer beats, applies backpressure to the FIFO, and aborts stalled frames.

Parameters:
- NUM_DATA, 1280, samples (FIFO words) per frame.
- TRIGGER_COUNTER_LENGTH, 16, width of trigger_count input (max 16).
- SAMPLE_WIDTH, 12, bits per ADC channel.
- TIMEOUT_CYCLES, 4096, consecutive data-starved cycles before a frame is aborted.
- MAGIC, 16'hCB01, header tag.

Ports:
- clk  in  1  40 MHz IP clock.
- rstn  in  1  asynchronous active-low reset.
- trigger_count  in  TRIGGER_COUNTER_LENGTH  chip trigger count, sampled at frame start.
- fifo_dout  in  4*SAMPLE_WIDTH  FIFO read data {ch3,ch2,ch1,ch0}, valid 1 cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- m_axis_tdata  out  32  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last beat of frame.
- frame_active  out  1  high from HDR0 entry until the trailer is accepted.
- frame_error  out  1  one-cycle pulse on timeout abort.
- frame_seq  out  32  count of completed frames.

Behaviour:
- Reset: all outputs 0; state IDLE; holding register empty; frame_seq 0. Reset mid-frame drops the frame immediately, emits no tlast, and leaves the FIFO as-is.
- Beat accepted when tvalid && tready. tdata and tlast stay stable while tvalid && !tready.
- States and transitions:
  - IDLE: if !fifo_empty, latch trigger_count (zero-extended to 16 bits), go to HDR0. No read in IDLE.
  - HDR0: tdata = {MAGIC, trig_latched}; on accept go to HDR1.
  - HDR1: tdata = frame_seq; on accept go to DATA_LO.
  - DATA_LO: tvalid = sample_vld; tdata = {4'h0, ch1, 4'h0, ch0}; on accept go to DATA_HI.
  - DATA_HI: tdata = {4'h0, ch3, 4'h0, ch2}.
    - On accept: sample_vld clears unless refilled the same cycle, and samples_sent increments.
    - If samples_sent+1 == NUM_DATA, go to TRAILER (or CHECKSUM when enabled); else go to DATA_LO.
  - TRAILER: tdata = {err, 15'h0, samples_sent[15:0]}; tlast = 1.
    - On accept: frame_seq += 1 (wraps at 2^32), clear err, return to IDLE.
- Holding register (one FIFO word):
  - fifo_rd_en = state in {HDR1, DATA_LO, DATA_HI} && !fifo_empty && words_requested < NUM_DATA && (!sample_vld || DATA_HI accept this cycle).
  - The returned word is loaded into sample_q one cycle later and sets sample_vld.
  - words_requested never exceeds NUM_DATA, so no over-read into the next frame.
  - The first read may issue in HDR1 to hide latency.
- Timeout:
  - The starve counter counts cycles in DATA_LO/DATA_HI with sample_vld=0 and no read in flight.
  - It resets on any data-beat accept.
  - Backpressure (tvalid && !tready) does not count.
  - On reaching TIMEOUT_CYCLES: set err, pulse frame_error, go to TRAILER (or CHECKSUM). A partially sent sample (LO sent, HI not) is counted as not sent.
- Simultaneous events:
  - fifo_empty deasserting in the same cycle as the TRAILER accept does not start a frame until the next IDLE cycle.
  - trigger_count changes after latch are ignored.
- Width rules: samples_sent is 16 bits; NUM_DATA ≤ 65535.

Optional Feature:
- Macro: ADC_READOUT_CHECKSUM_EN.
- When defined:
  - A CHECKSUM state is inserted before TRAILER.
  - tdata = 32-bit sum (mod 2^32) of all data beats (LO and HI) accepted in this frame.
  - The accumulator clears at HDR0.
  - tlast stays on TRAILER only.
- When undefined: no CHECKSUM state and no accumulator logic; the frame is exactly 2 + 2*samples_sent + 1 beats.

Test Plan:
- NUM_DATA=4, trigger_count=16'h0007, FIFO preloaded with 4 words, tready=1 -> beats CB010007, 00000000, 8 data beats, trailer 00000004 with tlast; frame_seq=1 after.
- Same frame with tready toggling 1-cycle-on/2-off -> identical beat sequence, tdata stable while stalled; fifo_rd_en never asserted while sample_vld=1 without HI accept.
- FIFO holds 2 of 4 words, TIMEOUT_CYCLES=16 -> after 16 starved cycles frame_error pulses once; trailer 80000002 with tlast; next frame header seq=1.
- Two back-to-back frames of 4 words (8 words in FIFO) -> second header CB01xxxx, seq 00000001; exactly 4 fifo_rd_en pulses per frame.
- rstn asserted mid-DATA_HI -> tvalid, frame_active, fifo_rd_en drop to 0 asynchronously; after release the next frame restarts with seq 0.
- ADC_READOUT_CHECKSUM_EN, samples all 12'h001 -> each data beat 00010001, checksum beat 00080008 (NUM_DATA=4), then trailer 00000004 with tlast.
